// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
// Bundles the pipeline request/response handshake and the memory-side bus of
// the load/store unit memory master.
//   master modport : the LSU memory master (drives req_ready, resp_*, mem_*)
//   slave  modport : the surrounding pipeline and memory model
// Signals:
//   req_valid/req_ready          request handshake
//   req_wen/req_size/req_signed  store flag, access size code, load sign mode
//   req_addr/req_wdata           byte address, right-aligned store data
//   resp_valid/resp_ready        response handshake
//   resp_rdata/resp_misalign     extended load data, misalignment flag
//   mem_addr/mem_wdata/mem_mask  doubleword address, lane-shifted data, byte enables
//   mem_enable/mem_wen           access strobe and write qualifier
//   mem_rdata                    combinational read data from memory
// -----------------------------------------------------------------------------
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_misalign;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_enable;
    logic        mem_wen;
    logic [63:0] mem_rdata;

    modport master (
        input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
        output mem_addr, mem_wdata, mem_mask, mem_enable, mem_wen
    );

    modport slave (
        output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
        input  mem_addr, mem_wdata, mem_mask, mem_enable, mem_wen
    );
endinterface

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Single-outstanding load/store memory master. Accepts one request from the
// pipeline, performs a single one-cycle access on a 64-bit doubleword memory
// bus (byte-lane shifted data and byte enables), extends load data and holds
// the response until the consumer takes it. Misaligned requests (when
// MISALIGN_CHECK=1) skip memory and respond immediately with a flag.
// Ports:
//   clk_i   : clock, all state updates on the rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : lsu_mem_master_if.master (request, response and memory bus)
// Timing: request accepted at edge N -> mem_enable in cycle N+1 -> resp_valid
// from cycle N+2 (misaligned: resp_valid from N+1, no memory strobe).
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    lsu_mem_master_if.master         bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        wen_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [2:0]  addr_lo_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic [7:0]  mem_mask_q;
    logic        mem_enable_q;
    logic        mem_wen_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_misalign_q;

    logic        req_misalign_d;
    logic [63:0] load_data_d;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic [2:0] low_bits;
        case (size)
            2'd0:    low_bits = 3'b000;
            2'd1:    low_bits = 3'b001;
            2'd2:    low_bits = 3'b011;
            2'd3:    low_bits = 3'b111;
            default: low_bits = 3'b111;
        endcase
        return (addr_lo & low_bits) != 3'b000;
    endfunction

    // Byte enables for the access, placed on the lanes selected by addr_lo.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] addr_lo);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            2'd3:    base = 8'hFF;
            default: base = 8'hFF;
        endcase
        return base << addr_lo;
    endfunction

    // Truncate right-aligned load data to the access size and extend it.
    function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                                input logic sgn);
        logic [63:0] ext;
        case (size)
            2'd0:    ext = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    ext = {{32{sgn & raw[31]}}, raw[31:0]};
            2'd3:    ext = raw;
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // Misalignment decision for the request currently offered.
    always_comb begin
        req_misalign_d = 1'b0;
        if (MISALIGN_CHECK) begin
            req_misalign_d = is_misaligned(bus.req_size, bus.req_addr[2:0]);
        end else begin
            req_misalign_d = 1'b0;
        end
    end

    // Load result: bring the addressed lane down to bit 0, then size and extend.
    always_comb begin
        load_data_d = 64'd0;
        load_data_d = load_extend(bus.mem_rdata >> {addr_lo_q, 3'b000}, size_q, signed_q);
    end

    // Control FSM with all outputs registered; the memory bus fields are
    // computed once at acceptance and simply held afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            req_ready_q     <= 1'b0;
            wen_q           <= 1'b0;
            size_q          <= 2'd0;
            signed_q        <= 1'b0;
            addr_lo_q       <= 3'd0;
            mem_addr_q      <= 64'd0;
            mem_wdata_q     <= 64'd0;
            mem_mask_q      <= 8'd0;
            mem_enable_q    <= 1'b0;
            mem_wen_q       <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 64'd0;
            resp_misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_ready_q && bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        wen_q       <= bus.req_wen;
                        size_q      <= bus.req_size;
                        signed_q    <= bus.req_signed;
                        addr_lo_q   <= bus.req_addr[2:0];
                        mem_addr_q  <= {bus.req_addr[63:3], 3'b000};
                        mem_wdata_q <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                        mem_mask_q  <= byte_mask(bus.req_size, bus.req_addr[2:0]);
                        if (req_misalign_d) begin
                            state_q         <= ST_RESP;
                            resp_valid_q    <= 1'b1;
                            resp_rdata_q    <= 64'd0;
                            resp_misalign_q <= 1'b1;
                        end else begin
                            state_q         <= ST_ACCESS;
                            mem_enable_q    <= 1'b1;
                            mem_wen_q       <= bus.req_wen;
                            resp_misalign_q <= 1'b0;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        req_ready_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state_q         <= ST_RESP;
                    mem_enable_q    <= 1'b0;
                    mem_wen_q       <= 1'b0;
                    resp_valid_q    <= 1'b1;
                    resp_misalign_q <= 1'b0;
                    resp_rdata_q    <= wen_q ? 64'd0 : load_data_d;
                end
                ST_RESP: begin
                    // Ready returns only after the handshake edge, so no request
                    // can be taken in the same cycle the response completes.
                    if (bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end else begin
                        state_q      <= ST_RESP;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    req_ready_q     <= 1'b0;
                    mem_enable_q    <= 1'b0;
                    mem_wen_q       <= 1'b0;
                    resp_valid_q    <= 1'b0;
                    resp_misalign_q <= 1'b0;
                    resp_rdata_q    <= 64'd0;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_mask      = mem_mask_q;
    assign bus.mem_enable    = mem_enable_q;
    assign bus.mem_wen       = mem_wen_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Self-checking bench for lsu_mem_master: directed vectors for the documented
// load/store/misalign/back-pressure/reset cases, then randomized requests
// checked against an arithmetic reference model of the access rules.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt   = 0;

    lsu_mem_master_if bus_if ();

    lsu_mem_master #(.MISALIGN_CHECK(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if.master)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Count cycles in which a memory strobe is presented.
    always @(posedge clk) begin
        if (bus_if.mem_enable === 1'b1) en_cnt <= en_cnt + 1;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference load result: lane select, size truncation, optional sign fill.
    function automatic logic [63:0] model_load(input logic [63:0] word, input int nbytes,
                                               input int off, input logic sgn);
        logic [63:0] raw;
        logic [63:0] keep;
        raw = word >> (8 * off);
        if (nbytes == 8) keep = {64{1'b1}};
        else             keep = (64'd1 << (8 * nbytes)) - 64'd1;
        raw = raw & keep;
        if (sgn && nbytes < 8 && raw[8*nbytes-1]) raw = raw | ~keep;
        return raw;
    endfunction

    task automatic run_txn(input logic wen, input logic [1:0] size, input logic sgn,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int hold);
        int          nb;
        int          off;
        logic        mis;
        logic [63:0] exp_r;
        logic [15:0] m16;
        logic [7:0]  exp_mask;
        logic [63:0] bmask;
        int          en0;
        int          waited;
        nb       = 1 << size;
        off      = int'(addr % 64'd8);
        mis      = (addr % 64'(nb)) != 64'd0;
        exp_r    = (wen || mis) ? 64'd0 : model_load(rdata, nb, off, sgn);
        m16      = 16'(((1 << nb) - 1) << off);
        exp_mask = m16[7:0];
        for (int i = 0; i < 8; i++) bmask[8*i +: 8] = exp_mask[i] ? 8'hFF : 8'h00;

        waited = 0;
        while (bus_if.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_value("req_ready_idle", bus_if.req_ready, 64'd1);

        bus_if.req_valid  = 1'b1;
        bus_if.req_wen    = wen;
        bus_if.req_size   = size;
        bus_if.req_signed = sgn;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        bus_if.mem_rdata  = rdata;
        en0 = en_cnt;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        check_value("req_ready_busy", bus_if.req_ready, 64'd0);
        if (mis) begin
            check_value("mis_mem_enable", bus_if.mem_enable, 64'd0);
            check_value("mis_resp_valid", bus_if.resp_valid, 64'd1);
            check_value("mis_flag", bus_if.resp_misalign, 64'd1);
            check_value("mis_rdata", bus_if.resp_rdata, 64'd0);
        end else begin
            check_value("mem_enable", bus_if.mem_enable, 64'd1);
            check_value("mem_wen", bus_if.mem_wen, 64'(wen));
            check_value("mem_addr", bus_if.mem_addr, addr & ~64'h7);
            check_value("mem_mask", bus_if.mem_mask, 64'(exp_mask));
            check_value("early_resp_valid", bus_if.resp_valid, 64'd0);
            if (wen) check_value("mem_wdata", bus_if.mem_wdata & bmask, (wdata << (8 * off)) & bmask);
            @(negedge clk);
            check_value("mem_enable_drop", bus_if.mem_enable, 64'd0);
            check_value("resp_valid", bus_if.resp_valid, 64'd1);
            check_value("resp_misalign", bus_if.resp_misalign, 64'd0);
            check_value("resp_rdata", bus_if.resp_rdata, exp_r);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_value("hold_valid", bus_if.resp_valid, 64'd1);
            check_value("hold_rdata", bus_if.resp_rdata, exp_r);
            check_value("hold_ready", bus_if.req_ready, 64'd0);
        end
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        bus_if.resp_ready = 1'b0;
        check_value("post_hs_valid", bus_if.resp_valid, 64'd0);
        check_value("post_hs_ready", bus_if.req_ready, 64'd1);
        check_value("en_pulses", 64'(en_cnt - en0), mis ? 64'd0 : 64'd1);
    endtask

    initial begin
        int          en0;
        logic [1:0]  sz;
        logic [63:0] a;
        bus_if.req_valid  = 1'b0;
        bus_if.req_wen    = 1'b0;
        bus_if.req_size   = 2'd0;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = 64'd0;
        bus_if.req_wdata  = 64'd0;
        bus_if.resp_ready = 1'b0;
        bus_if.mem_rdata  = 64'd0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_value("rst_req_ready", bus_if.req_ready, 64'd0);
        check_value("rst_resp_valid", bus_if.resp_valid, 64'd0);
        check_value("rst_resp_rdata", bus_if.resp_rdata, 64'd0);
        check_value("rst_misalign", bus_if.resp_misalign, 64'd0);
        check_value("rst_mem_enable", bus_if.mem_enable, 64'd0);
        check_value("rst_mem_wen", bus_if.mem_wen, 64'd0);
        check_value("rst_mem_addr", bus_if.mem_addr, 64'd0);
        check_value("rst_mem_mask", bus_if.mem_mask, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("ready_after_rst", bus_if.req_ready, 64'd1);

        // Directed vectors
        run_txn(1'b0, 2'd0, 1'b1, 64'h0000_0000_8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 0);
        check_value("lb_vector", bus_if.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_txn(1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 64'd0, 0);
        run_txn(1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0004, 64'd0, 64'h89AB_CDEF_0000_0000, 0);
        check_value("lw_vector", bus_if.resp_rdata, 64'h0000_0000_89AB_CDEF);
        run_txn(1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0004, 64'd0, 64'h1122_3344_5566_7788, 0);
        run_txn(1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0008, 64'd0, 64'h0000_0000_F000_0001, 5);
        run_txn(1'b0, 2'd3, 1'b1, 64'h0000_0000_8000_0010, 64'd0, 64'h8000_0000_0000_0001, 2);

        // Reset pulse in the middle of an access
        bus_if.req_valid = 1'b1;
        bus_if.req_wen   = 1'b0;
        bus_if.req_size  = 2'd2;
        bus_if.req_addr  = 64'h0000_0000_0000_0010;
        en0 = en_cnt;
        @(posedge clk);
        #2;
        bus_if.req_valid = 1'b0;
        check_value("abort_en_before", bus_if.mem_enable, 64'd1);
        rst_n = 1'b0;
        #1;
        check_value("abort_en_async", bus_if.mem_enable, 64'd0);
        check_value("abort_ready", bus_if.req_ready, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("abort_no_resp", bus_if.resp_valid, 64'd0);
        end
        check_value("abort_no_pulse", 64'(en_cnt - en0), 64'd0);
        run_txn(1'b0, 2'd1, 1'b0, 64'h0000_0000_0000_0022, 64'd0, 64'h0000_0000_0000_BEEF_0000 << 0, 0);

        // Randomized requests against the reference model
        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 64'd1);
            run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                    {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter: MISALIGN_CHECK, default 1, meaning 1 = flag and suppress misaligned accesses, 0 = no alignment check.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline request present.
REQ-005 req_ready  output  1  block accepts request this cycle.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, right-aligned in bits [8*size_bytes-1:0].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  consumer accepts response.
REQ-013 resp_rdata  output  64  extended load data; 0 for stores and misaligned requests.
REQ-014 resp_misalign  output  1  request was misaligned; no memory access performed.
REQ-015 mem_addr  output  64  doubleword-aligned address to memory (req_addr with bits [2:0] cleared).
REQ-016 mem_wdata  output  64  store data shifted left by 8*req_addr[2:0].
REQ-017 mem_mask  output  8  byte enables: (2^size_bytes - 1) shifted left by req_addr[2:0].
REQ-018 mem_enable  output  1  memory access strobe.
REQ-019 mem_wen  output  1  write strobe qualifier.
REQ-020 mem_rdata  input  64  memory read data, valid combinationally within the cycle mem_enable=1 and mem_wen=0.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; encoding at implementer's discretion.
REQ-022 IDLE: req_ready=1; on req_valid, latch wen/size/signed/addr/wdata; next state ACCESS if aligned, else RESP with misalign flag set.
REQ-023 Misaligned means req_addr mod size_bytes != 0 (size_bytes = 1<<req_size); byte accesses are never misaligned; with MISALIGN_CHECK=0 every request is aligned.
REQ-024 ACCESS lasts exactly one cycle: mem_enable=1, mem_wen=latched wen, mem_addr/mem_wdata/mem_mask from latched request; next state RESP.
REQ-025 Loads: at the rising edge ending ACCESS, capture mem_rdata >> 8*addr[2:0], truncate to size_bytes, then sign- or zero-extend per latched signed into resp_rdata; size 3 ignores signed.
REQ-026 Stores: resp_rdata = 0.
REQ-027 RESP: resp_valid=1, resp_rdata and resp_misalign held stable until the cycle resp_ready=1; next state IDLE.
REQ-028 req_ready=0 in ACCESS and RESP; no request is accepted in the cycle the response handshake completes (RESP -> IDLE takes one cycle).
REQ-029 Outside ACCESS: mem_enable=0 and mem_wen=0; mem_addr/mem_wdata/mem_mask are don't-care but SHALL be deterministic (hold latched values).
REQ-030 Latency: request accepted at edge N, mem_enable high in cycle N+1, resp_valid high from cycle N+2; misaligned: resp_valid from cycle N+1, zero memory strobes.
REQ-031 Exactly one mem_enable pulse per aligned request; never more than one outstanding request.
REQ-032 Stores with size < 3 SHALL only set mask bits for written bytes; mem_wdata bytes outside mask are don't-care.

Reset
REQ-033 reset low asynchronously forces state IDLE, req_ready=1 only after reset deasserts, resp_valid=0, resp_misalign=0, resp_rdata=0, mem_enable=0, mem_wen=0, latched request registers 0.
REQ-034 reset asserted during ACCESS drops mem_enable immediately; aborted request produces no response.
REQ-035 While reset is low, req_ready=0.

Verification
REQ-036 Load byte signed, addr 0x80000003, mem_rdata 0x00000000_80FF0000 -> mem_mask 0x08, mem_addr 0x80000000, resp_rdata 0xFFFFFFFF_FFFFFF80 at cycle N+2.
REQ-037 Store half, addr 0x80000006, wdata 0x1234 -> one-cycle mem_enable=1, mem_wen=1, mem_mask 0xC0, mem_wdata[63:48]=0x1234, resp_rdata 0.
REQ-038 Load word unsigned, addr 0x80000004, mem_rdata 0x89ABCDEF_00000000 -> resp_rdata 0x00000000_89ABCDEF.
REQ-039 Load double addr 0x80000004 (MISALIGN_CHECK=1) -> no mem_enable pulse, resp_valid at N+1 with resp_misalign=1, resp_rdata 0.
REQ-040 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, no second mem_enable; release -> IDLE next cycle.
REQ-041 reset pulsed low mid-ACCESS -> mem_enable falls without clock edge, resp_valid never asserts, next request completes normally.
